pixel_streamer: RTL



---
 rtl/pixel_streamer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pixel_streamer.sv
// pixel_streamer: single-frame source for the convolution line buffer.
//
// The host loads one WIDTH x HEIGHT image into an internal frame store while
// the block is idle. A start pulse then streams the image in raster order,
// one pixel per cycle when out_ready_i is high, with end-of-line and
// end-of-frame markers and a one-cycle frame_done_o pulse after the last pixel.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset (frame store is not cleared)
//   wr_en_i      host write strobe (honoured only while idle)
//   wr_addr_i    raster address row*WIDTH+col; addresses >= WIDTH*HEIGHT ignored
//   wr_data_i    pixel value to store
//   start_i      begin streaming one frame (ignored while streaming)
//   out_ready_i  downstream accepts a pixel this cycle
//   data_out_o   streamed pixel (registered, holds when no pixel is issued)
//   out_val_o    data_out_o is valid this cycle
//   eol_o        current valid pixel is the last column of its row
//   eof_o        current valid pixel is the last pixel of the frame
//   busy_o       frame streaming in progress
//   frame_done_o one-cycle pulse on the cycle after the last pixel
module pixel_streamer #(
    parameter int unsigned WIDTH     = 28,
    parameter int unsigned HEIGHT    = 28,
    parameter int unsigned DATA_BITS = 8,
    localparam int unsigned AW       = $clog2(WIDTH * HEIGHT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    input  logic                 start_i,
    input  logic                 out_ready_i,
    output logic [DATA_BITS-1:0] data_out_o,
    output logic                 out_val_o,
    output logic                 eol_o,
    output logic                 eof_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);

    localparam int unsigned Pixels = WIDTH * HEIGHT;
    localparam int unsigned ColW   = $clog2(WIDTH + 1);
    localparam int unsigned RowW   = $clog2(HEIGHT + 1);

    localparam logic [AW-1:0]   LastAddr = AW'(Pixels - 1);
    localparam logic [AW-1:0]   PtrOne   = AW'(1);
    localparam logic [ColW-1:0] ColLast  = ColW'(WIDTH - 1);
    localparam logic [ColW-1:0] ColOne   = ColW'(1);
    localparam logic [RowW-1:0] RowOne   = RowW'(1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [ColW-1:0]      col_q, col_d;
    logic [RowW-1:0]      row_q, row_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 out_val_q, out_val_d;
    logic                 eol_q, eol_d;
    logic                 eof_q, eof_d;
    logic                 last_q, last_d;       // last pixel issued on previous edge
    logic                 frame_done_q, frame_done_d;

    logic                 mem_we;
    logic [DATA_BITS-1:0] mem [Pixels];

    // Frame store: no reset so image survives rst_i.
    assign mem_we = wr_en_i && (state_q == StIdle) && (32'(wr_addr_i) < Pixels);

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        col_d        = col_q;
        row_d        = row_q;
        data_out_d   = data_out_q;
        out_val_d    = 1'b0;
        eol_d        = 1'b0;
        eof_d        = 1'b0;
        last_d       = 1'b0;
        frame_done_d = last_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StStream;
                    rd_ptr_d = '0;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
            StStream: begin
                if (out_ready_i) begin
                    // Registered read of the store is the synchronous read port.
                    data_out_d = mem[rd_ptr_q];
                    out_val_d  = 1'b1;
                    eol_d      = (col_q == ColLast);
                    eof_d      = (rd_ptr_q == LastAddr);
                    rd_ptr_d   = rd_ptr_q + PtrOne;
                    if (col_q == ColLast) begin
                        col_d = '0;
                        row_d = row_q + RowOne;
                    end else begin
                        col_d = col_q + ColOne;
                    end
                    if (rd_ptr_q == LastAddr) begin
                        state_d = StIdle;
                        last_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            rd_ptr_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            data_out_q   <= '0;
            out_val_q    <= 1'b0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            data_out_q   <= data_out_d;
            out_val_q    <= out_val_d;
            eol_q        <= eol_d;
            eof_q        <= eof_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_out_o   = data_out_q;
    assign out_val_o    = out_val_q;
    assign eol_o        = eol_q;
    assign eof_o        = eof_q;
    assign busy_o       = (state_q == StStream);
    assign frame_done_o = frame_done_q;

endmodule
